fp_mult_pipe: RTL and testbench
===============================

Name: fp_mult_pipe

Overview:
- Pipelined, parametrised IEEE-754-style floating-point multiplier for the FPU datapath.
- Successor to the combinational single-precision multiplier. Adds:
  - generic exponent/mantissa widths;
  - round-to-nearest-even;
  - full special-value handling (NaN, Inf, zero);
  - exception flags;
  - a valid/ready stream interface with an in-order tag.
- Sits between the FPU operand-issue stage and the result writeback arbiter.

Parameters:
- EXP_WIDTH, 8: exponent field width.
- MAN_WIDTH, 23: stored mantissa (fraction) width.
- TAG_WIDTH, 4: width of the opaque tag passed alongside each operation.
- Derived, not overridable:
  - WIDTH = 1+EXP_WIDTH+MAN_WIDTH.
  - BIAS = 2^(EXP_WIDTH-1)-1.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_tag  in  TAG_WIDTH  tag carried to output unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  product.
- out_tag  out  TAG_WIDTH  tag of this result.
- out_flags  out  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Reset:
  - rst=1 asynchronously clears all stage valid bits.
  - out_valid=0; out_result, out_tag and out_flags = 0.
  - Data registers need no reset, but the out_* registers do.
  - Reset mid-operation discards every in-flight op with no output.
- Pipeline: 3 stages, fixed latency 3 cycles from acceptance to out_valid when out_ready stays high.
- Handshake:
  - Global advance enable en = !out_valid | out_ready; in_ready = en.
  - Transfers occur when valid&ready.
  - When en=0 all stages hold; out_* stay stable while out_valid=1 and out_ready=0.
  - Bubbles are not compressed.
  - Ordering is strictly FIFO. Throughput is 1 op/cycle with no stalls.
- S1 (unpack/classify/multiply):
  - Sign = sa^sb.
  - Class per operand: zero (exp=0, subnormals flushed to zero), normal, inf (exp all ones, frac 0), NaN (exp all ones, frac≠0), sNaN (NaN with frac MSB=0).
  - Significands {1,frac} multiplied into a 2*MAN_WIDTH+2-bit product.
  - Exponent sum ea+eb-BIAS computed signed, EXP_WIDTH+2 bits.
- S2 (normalise):
  - If product MSB=1: take the upper MAN_WIDTH bits below the MSB and add 1 to the exponent; else shift by one position.
  - Form guard = next bit and sticky = OR of all remaining bits.
- S3 (round/pack):
  - RNE: increment when guard & (sticky | lsb).
  - Mantissa carry-out: exponent+1, fraction=0.
  - Final exponent e ≥ 2^EXP_WIDTH-1: signed Inf, overflow=1, inexact=1.
  - e ≤ 0: signed zero, underflow=1, inexact=1.
  - Otherwise pack {sign, e, frac}; inexact = guard|sticky.
- Specials (override arithmetic; only invalid may be set):
  - Any NaN operand, or Inf×zero: canonical qNaN {0, all ones, 1, zeros}.
  - invalid=1 for Inf×zero or any sNaN; a qNaN operand alone gives invalid=0.
  - Inf×(normal or Inf): signed Inf.
  - zero×(normal or zero): signed zero.
- Width rule: exponent arithmetic is signed with 2 guard bits, so no wrap-around occurs for any pair of operand exponents.

Decomposition:
- Shared package fpu_pkg holds:
  - the class enum (ZERO, NORM, INF, QNAN, SNAN);
  - the flag bit indices;
  - a function for canonical-qNaN construction from EXP_WIDTH/MAN_WIDTH.
- One natural sub-module: fp_round_pack (S3 rounding, over/underflow detection, packing). It is reusable by the planned adder pipeline.

Test Plan:
- 0x3FC00000 × 0x40000000 (1.5×2.0), out_ready=1:
  - out 0x40400000, flags 0000;
  - out_valid exactly 3 cycles after acceptance;
  - tag preserved.
- 0x3F800001 × 0x3F800001:
  - out 0x3F800002, inexact=1, others 0 (RNE drops 2^-46 sticky).
- 0x7F7FFFFF × 0x40000000:
  - out 0x7F800000, overflow=1, inexact=1.
- Underflow, 0x00800000 × 0x3F000000:
  - out 0x00000000, underflow=1, inexact=1.
- Specials, one case per op:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1.
  - 0xFF800000 × 0x40000000 → 0xFF800000, flags 0.
  - 0x7FA00000 × 0x3F800000 → 0x7FC00000, invalid=1.
- Backpressure and reset:
  - Issue 6 back-to-back ops with tags 0–5 and hold out_ready=0 for cycles 3–6.
  - Results must be in tag order with no loss or duplication, and out_* stable while stalled.
  - Then assert rst mid-stream: out_valid drops within the same cycle, and no stale result appears after release.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operand classes, exception flag layout and canonical NaN.
package fpu_pkg;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } fp_class_e;

  localparam int unsigned FLAG_INEXACT   = 0;
  localparam int unsigned FLAG_UNDERFLOW = 1;
  localparam int unsigned FLAG_OVERFLOW  = 2;
  localparam int unsigned FLAG_INVALID   = 3;
  localparam int unsigned FLAG_WIDTH     = 4;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  // Canonical quiet NaN {0, all-ones exponent, 1, zeros}, right-aligned in 64 bits.
  function automatic logic [63:0] canonical_qnan(input int unsigned exp_width,
                                                 input int unsigned man_width);
    logic [63:0] r;
    r = ((64'd1 << exp_width) - 64'd1) << man_width;
    r = r | (64'd1 << (man_width - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_mult_pipe_if.sv
// Valid/ready operand and result stream bundle for the pipelined FP multiplier.
interface fp_mult_pipe_if #(
  parameter int unsigned EXP_WIDTH = 8,
  parameter int unsigned MAN_WIDTH = 23,
  parameter int unsigned TAG_WIDTH = 4
);
  localparam int unsigned WIDTH = 1 + EXP_WIDTH + MAN_WIDTH;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_result;
  logic [TAG_WIDTH-1:0] out_tag;
  logic [3:0]           out_flags;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_flags
  );
endinterface

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even, overflow/underflow detection and IEEE packing of a
// normalised significand; shared with the adder pipeline.
module fp_round_pack
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_WIDTH = 8,
  parameter int unsigned MAN_WIDTH = 23
) (
  input  logic                          sign,
  input  logic signed [EXP_WIDTH+1:0]   exponent,
  input  logic        [MAN_WIDTH-1:0]   mant,
  input  logic                          guard,
  input  logic                          sticky,
  output logic [EXP_WIDTH+MAN_WIDTH:0]  result_c,
  output fp_flags_t                     flags_c
);
  localparam int unsigned XW = EXP_WIDTH + 2;
  localparam logic signed [XW-1:0] EXP_MAX  = XW'(2**EXP_WIDTH - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;

  logic                 inc;
  logic [MAN_WIDTH:0]   mant_r;
  logic signed [XW-1:0] exp_r;

  always_comb begin
    inc      = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + (MAN_WIDTH+1)'(inc);
    // A carry out of the fraction leaves it all-zero; only the exponent moves.
    exp_r    = exponent + $signed(XW'(mant_r[MAN_WIDTH]));
    result_c = '0;
    flags_c  = '0;
    if (exp_r >= EXP_MAX) begin
      result_c          = {sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
      flags_c.overflow  = 1'b1;
      flags_c.inexact   = 1'b1;
    end else if (exp_r <= EXP_ZERO) begin
      result_c          = {sign, {(EXP_WIDTH+MAN_WIDTH){1'b0}}};
      flags_c.underflow = 1'b1;
      flags_c.inexact   = 1'b1;
    end else begin
      result_c          = {sign, exp_r[EXP_WIDTH-1:0], mant_r[MAN_WIDTH-1:0]};
      flags_c.inexact   = guard | sticky;
    end
  end
endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage IEEE-754-style multiplier: S1 classify/multiply, S2 normalise,
// S3 round/pack into the output registers. Single global stall enable.
module fp_mult_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_WIDTH = 8,
  parameter int unsigned MAN_WIDTH = 23,
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  fp_mult_pipe_if.slave bus
);
  localparam int unsigned WIDTH = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int unsigned XW    = EXP_WIDTH + 2;
  localparam int unsigned PW    = 2 * MAN_WIDTH + 2;
  localparam logic [XW-1:0]        BIAS_X = XW'(2**(EXP_WIDTH-1) - 1);
  localparam logic signed [XW-1:0] ONE_X  = 1;
  localparam logic [WIDTH-1:0]     QNAN_W = WIDTH'(canonical_qnan(EXP_WIDTH, MAN_WIDTH));

  function automatic fp_class_e classify(input logic [EXP_WIDTH-1:0] e,
                                         input logic [MAN_WIDTH-1:0] f);
    if (e == '0) return CLS_ZERO;
    if (e != '1) return CLS_NORM;
    if (f == '0) return CLS_INF;
    return f[MAN_WIDTH-1] ? CLS_QNAN : CLS_SNAN;
  endfunction

  logic en;

  // S1 combinational: classify, special-case result, significand product
  fp_class_e            cls_a, cls_b;
  logic                 p_sign, p_special, p_invalid;
  logic [WIDTH-1:0]     p_spec_res;
  logic [PW-1:0]        p_prod;
  logic signed [XW-1:0] p_exp;
  logic                 a_nan, b_nan, a_zero, b_zero, inf_zero;

  always_comb begin
    cls_a      = classify(bus.in_a[WIDTH-2:MAN_WIDTH], bus.in_a[MAN_WIDTH-1:0]);
    cls_b      = classify(bus.in_b[WIDTH-2:MAN_WIDTH], bus.in_b[MAN_WIDTH-1:0]);
    p_sign     = bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
    p_prod     = PW'({1'b1, bus.in_a[MAN_WIDTH-1:0]}) * PW'({1'b1, bus.in_b[MAN_WIDTH-1:0]});
    p_exp      = $signed(XW'(bus.in_a[WIDTH-2:MAN_WIDTH]) + XW'(bus.in_b[WIDTH-2:MAN_WIDTH]) - BIAS_X);
    a_nan      = (cls_a == CLS_QNAN) || (cls_a == CLS_SNAN);
    b_nan      = (cls_b == CLS_QNAN) || (cls_b == CLS_SNAN);
    a_zero     = (cls_a == CLS_ZERO);
    b_zero     = (cls_b == CLS_ZERO);
    inf_zero   = ((cls_a == CLS_INF) && b_zero) || ((cls_b == CLS_INF) && a_zero);
    p_special  = 1'b0;
    p_invalid  = 1'b0;
    p_spec_res = '0;
    if (a_nan || b_nan || inf_zero) begin
      p_special  = 1'b1;
      p_spec_res = QNAN_W;
      p_invalid  = (cls_a == CLS_SNAN) || (cls_b == CLS_SNAN) || inf_zero;
    end else if ((cls_a == CLS_INF) || (cls_b == CLS_INF)) begin
      p_special  = 1'b1;
      p_spec_res = {p_sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
    end else if (a_zero || b_zero) begin
      p_special  = 1'b1;
      p_spec_res = {p_sign, {(WIDTH-1){1'b0}}};
    end
  end

  logic                 s1_valid, s1_sign, s1_special, s1_invalid;
  logic [WIDTH-1:0]     s1_spec_res;
  logic [PW-1:0]        s1_prod;
  logic signed [XW-1:0] s1_exp;
  logic [TAG_WIDTH-1:0] s1_tag;

  // S2 combinational: normalise the product to 1.f with guard and sticky
  logic [MAN_WIDTH-1:0] n_mant;
  logic                 n_guard, n_sticky;
  logic signed [XW-1:0] n_exp;

  always_comb begin
    if (s1_prod[PW-1]) begin
      n_mant   = s1_prod[PW-2 -: MAN_WIDTH];
      n_guard  = s1_prod[PW-2-MAN_WIDTH];
      n_sticky = |s1_prod[PW-3-MAN_WIDTH:0];
      n_exp    = s1_exp + ONE_X;
    end else begin
      n_mant   = s1_prod[PW-3 -: MAN_WIDTH];
      n_guard  = s1_prod[PW-3-MAN_WIDTH];
      n_sticky = |s1_prod[PW-4-MAN_WIDTH:0];
      n_exp    = s1_exp;
    end
  end

  logic                 s2_valid, s2_sign, s2_special, s2_invalid, s2_guard, s2_sticky;
  logic [WIDTH-1:0]     s2_spec_res;
  logic [MAN_WIDTH-1:0] s2_mant;
  logic signed [XW-1:0] s2_exp;
  logic [TAG_WIDTH-1:0] s2_tag;

  logic [WIDTH-1:0]     rp_result;
  fp_flags_t            rp_flags, sp_flags;

  fp_round_pack #(
    .EXP_WIDTH (EXP_WIDTH),
    .MAN_WIDTH (MAN_WIDTH)
  ) u_round_pack (
    .sign     (s2_sign),
    .exponent (s2_exp),
    .mant     (s2_mant),
    .guard    (s2_guard),
    .sticky   (s2_sticky),
    .result_c (rp_result),
    .flags_c  (rp_flags)
  );

  always_comb begin
    sp_flags         = '0;
    sp_flags.invalid = s2_invalid;
  end

  logic                 out_valid_q;
  logic [WIDTH-1:0]     out_result_q;
  logic [TAG_WIDTH-1:0] out_tag_q;
  fp_flags_t            out_flags_q;

  assign en = !out_valid_q || bus.out_ready;

  // Stage valid bits: the only control state, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= bus.in_valid;
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      s1_sign     <= p_sign;
      s1_special  <= p_special;
      s1_invalid  <= p_invalid;
      s1_spec_res <= p_spec_res;
      s1_prod     <= p_prod;
      s1_exp      <= p_exp;
      s1_tag      <= bus.in_tag;
      s2_sign     <= s1_sign;
      s2_special  <= s1_special;
      s2_invalid  <= s1_invalid;
      s2_spec_res <= s1_spec_res;
      s2_mant     <= n_mant;
      s2_guard    <= n_guard;
      s2_sticky   <= n_sticky;
      s2_exp      <= n_exp;
      s2_tag      <= s1_tag;
    end
  end

  // S3: output registers; specials override the arithmetic result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_flags_q  <= '0;
    end else if (en) begin
      out_valid_q <= s2_valid;
      if (s2_valid) begin
        out_result_q <= s2_special ? s2_spec_res : rp_result;
        out_flags_q  <= s2_special ? sp_flags : rp_flags;
        out_tag_q    <= s2_tag;
      end
    end
  end

  assign bus.in_ready   = en;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.out_flags  = out_flags_q;
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed-vector bench for fp_mult_pipe: arithmetic, rounding, specials,
// backpressure ordering and mid-stream reset.
module tb_fp_mult_pipe;
  import fpu_pkg::*;

  localparam int unsigned EW = 8;
  localparam int unsigned MW = 23;
  localparam int unsigned TW = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  fp_mult_pipe_if #(.EXP_WIDTH(EW), .MAN_WIDTH(MW), .TAG_WIDTH(TW)) bus ();

  fp_mult_pipe #(.EXP_WIDTH(EW), .MAN_WIDTH(MW), .TAG_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Issue one op with out_ready high; report result and edges until out_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                        output logic [31:0] res, output logic [3:0] flg,
                        output logic [3:0] tg, output int lat);
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = tag;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.out_result;
    flg = bus.out_flags;
    tg  = bus.out_tag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.out_valid); else passed++;
    checks++; if (bus.out_result !== 32'h0) $display("FAIL reset_result: got %h expected 0", bus.out_result); else passed++;
    checks++; if (bus.out_tag !== 4'h0) $display("FAIL reset_tag: got %h expected 0", bus.out_tag); else passed++;
    checks++; if (bus.out_flags !== 4'h0) $display("FAIL reset_flags: got %b expected 0000", bus.out_flags); else passed++;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    vec_t v[3] = '{
      '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000},  // 1.5*2
      '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000},  // -2*3
      '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000}   // 1.5*1.5, product MSB set
    };
    logic [31:0] res; logic [3:0] flg, tg; int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(v[i].a, v[i].b, 4'(4'hA + i), res, flg, tg, lat);
      checks++; if (res !== v[i].r) $display("FAIL basic_result[%0d]: got %h expected %h", i, res, v[i].r); else passed++;
      checks++; if (flg !== v[i].f) $display("FAIL basic_flags[%0d]: got %b expected %b", i, flg, v[i].f); else passed++;
      checks++; if (lat != 3) $display("FAIL basic_latency[%0d]: got %0d expected 3", i, lat); else passed++;
      checks++; if (tg !== 4'(4'hA + i)) $display("FAIL basic_tag[%0d]: got %h expected %h", i, tg, 4'(4'hA + i)); else passed++;
    end
  endtask

  task automatic test_rounding();
    vec_t v[3] = '{
      '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001},  // sticky only, no increment
      '{32'h3F800800, 32'h3F800800, 32'h3F801000, 4'b0001},  // exact tie, lsb even stays
      '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001}   // exact tie, lsb odd rounds up
    };
    logic [31:0] res; logic [3:0] flg, tg; int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(v[i].a, v[i].b, 4'(i), res, flg, tg, lat);
      checks++; if (res !== v[i].r) $display("FAIL round_result[%0d]: got %h expected %h", i, res, v[i].r); else passed++;
      checks++; if (flg !== v[i].f) $display("FAIL round_flags[%0d]: got %b expected %b", i, flg, v[i].f); else passed++;
    end
  endtask

  task automatic test_range();
    vec_t v[2] = '{
      '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101},  // overflow to +Inf
      '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011}   // underflow to +0
    };
    logic [31:0] res; logic [3:0] flg, tg; int lat;
    for (int i = 0; i < 2; i++) begin
      run_op(v[i].a, v[i].b, 4'(i), res, flg, tg, lat);
      checks++; if (res !== v[i].r) $display("FAIL range_result[%0d]: got %h expected %h", i, res, v[i].r); else passed++;
      checks++; if (flg !== v[i].f) $display("FAIL range_flags[%0d]: got %b expected %b", i, flg, v[i].f); else passed++;
    end
  endtask

  task automatic test_specials();
    vec_t v[6] = '{
      '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000},  // Inf*0
      '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000},  // -Inf*2
      '{32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b1000},  // sNaN
      '{32'h7FC00000, 32'h40000000, 32'h7FC00000, 4'b0000},  // qNaN, no invalid
      '{32'h00000000, 32'hC0000000, 32'h80000000, 4'b0000},  // 0*-2
      '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000}   // subnormal flushed
    };
    logic [31:0] res; logic [3:0] flg, tg; int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(v[i].a, v[i].b, 4'(i), res, flg, tg, lat);
      checks++; if (res !== v[i].r) $display("FAIL special_result[%0d]: got %h expected %h", i, res, v[i].r); else passed++;
      checks++; if (flg !== v[i].f) $display("FAIL special_flags[%0d]: got %b expected %b", i, flg, v[i].f); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[6] = '{
      '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000},
      '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000},
      '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001},
      '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101},
      '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000},
      '{32'h00000000, 32'hC0000000, 32'h80000000, 4'b0000}
    };
    int issued = 0, got = 0, extra = 0, cyc = 0;
    @(posedge clk); #1;
    while (got < 6 && cyc < 60) begin
      bus.in_valid  = (issued < 6);
      if (issued < 6) begin
        bus.in_a = v[issued].a; bus.in_b = v[issued].b; bus.in_tag = 4'(issued);
      end
      bus.out_ready = !(cyc >= 3 && cyc <= 6);
      @(negedge clk);
      if (bus.out_valid) begin
        checks++; if (bus.out_tag !== 4'(got)) $display("FAIL b2b_tag cyc%0d: got %h expected %h", cyc, bus.out_tag, 4'(got)); else passed++;
        checks++; if (bus.out_result !== v[got].r) $display("FAIL b2b_result cyc%0d: got %h expected %h", cyc, bus.out_result, v[got].r); else passed++;
        checks++; if (bus.out_flags !== v[got].f) $display("FAIL b2b_flags cyc%0d: got %b expected %b", cyc, bus.out_flags, v[got].f); else passed++;
        if (bus.out_ready) got++;
      end
      if (bus.in_valid && bus.in_ready) issued++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++; if (got != 6) $display("FAIL b2b_count: got %0d expected 6", got); else passed++;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    checks++; if (extra != 0) $display("FAIL b2b_duplicate: got %0d extra results expected 0", extra); else passed++;
  endtask

  task automatic test_reset_midstream();
    int stale = 0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 32'h3FC00000;
    bus.in_b      = 32'h40000000;
    bus.in_tag    = 4'h8;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bus.in_tag = 4'(bus.in_tag + 4'h1);
    end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'h8)
      $display("FAIL rst_pre: got valid %b tag %h expected valid 1 tag 8", bus.out_valid, bus.out_tag); else passed++;
    #2 rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_async_valid: got %b expected 0", bus.out_valid); else passed++;
    checks++; if (bus.out_result !== 32'h0) $display("FAIL rst_async_result: got %h expected 0", bus.out_result); else passed++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    checks++; if (stale != 0) $display("FAIL rst_stale: got %0d results expected 0", stale); else passed++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_range();
    test_specials();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
